reg_file: RTL and testbench

REG_FILE -- requirements
Module: reg_file

---
 rtl/reg_file.sv | 77 +++++++
 tb/tb_reg_file.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/reg_file.sv
// General-purpose register file with two independent combinational read ports,
// one write port and registered zero/negative status flags captured from busD.
module reg_file #(
  parameter int WIDTH     = 16,
  parameter int REG_COUNT = 8,
  localparam int SEL_W    = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [SEL_W-1:0]        regSelA,
  input  logic [SEL_W-1:0]        regSelB,
  input  logic [SEL_W-1:0]        regSelD,
  input  logic                    regOutA,
  input  logic                    regOutB,
  input  logic                    regLoad,
  input  logic                    flagLoad,
  input  logic signed [WIDTH-1:0] busD,
  output logic signed [WIDTH-1:0] busA,
  output logic signed [WIDTH-1:0] busB,
  output logic                    flagZ,
  output logic                    flagN
);

  logic [WIDTH-1:0] regs_q [REG_COUNT];
  logic [WIDTH-1:0] regs_d [REG_COUNT];
  logic             flag_z_q, flag_z_d;
  logic             flag_n_q, flag_n_d;

  // Index 0 is the hardwired zero register; indices past REG_COUNT do not exist.
  function automatic logic sel_valid(input logic [SEL_W-1:0] sel);
    return (sel != '0) && (32'(sel) < REG_COUNT);
  endfunction

  always_comb begin
    regs_d   = regs_q;
    flag_z_d = flag_z_q;
    flag_n_d = flag_n_q;
    if (regLoad && sel_valid(regSelD)) begin
      regs_d[regSelD] = busD;
    end
    if (flagLoad) begin
      flag_z_d = (busD == '0);
      flag_n_d = busD[WIDTH-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        regs_q[i] <= '0;
      end
      flag_z_q <= 1'b0;
      flag_n_q <= 1'b0;
    end else begin
      regs_q   <= regs_d;
      flag_z_q <= flag_z_d;
      flag_n_q <= flag_n_d;
    end
  end

  // Reads come only from the stored state, never from busD, so the
  // busA -> ALU -> busD path cannot close a combinational loop.
  always_comb begin
    busA = '0;
    busB = '0;
    if (regOutA && sel_valid(regSelA)) begin
      busA = regs_q[regSelA];
    end
    if (regOutB && sel_valid(regSelB)) begin
      busB = regs_q[regSelB];
    end
  end

  assign flagZ = flag_z_q;
  assign flagN = flag_n_q;

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed vector table followed by random
// traffic compared against an array-based reference model.
module tb_reg_file;

  localparam int WIDTH     = 16;
  localparam int REG_COUNT = 8;
  localparam int SEL_W     = 3;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [SEL_W-1:0]        regSelA, regSelB, regSelD;
  logic                    regOutA, regOutB, regLoad, flagLoad;
  logic signed [WIDTH-1:0] busD;
  logic signed [WIDTH-1:0] busA, busB;
  logic                    flagZ, flagN;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic             rst;
    logic [SEL_W-1:0] sel_a, sel_b, sel_d;
    logic             out_a, out_b, load, fload;
    logic [WIDTH-1:0] bus_d;
    logic [WIDTH-1:0] exp_a, exp_b;
    logic             exp_z, exp_n;
  } vec_t;

  vec_t vecs[$];

  reg_file #(.WIDTH(WIDTH), .REG_COUNT(REG_COUNT)) dut (
    .clk     (clk),
    .rst     (rst),
    .regSelA (regSelA),
    .regSelB (regSelB),
    .regSelD (regSelD),
    .regOutA (regOutA),
    .regOutB (regOutB),
    .regLoad (regLoad),
    .flagLoad(flagLoad),
    .busD    (busD),
    .busA    (busA),
    .busB    (busB),
    .flagZ   (flagZ),
    .flagN   (flagN)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input int r, input int sa, input int sb, input int sd,
                              input int oa, input int ob, input int ld, input int fl,
                              input int bd, input int ea, input int eb,
                              input int ez, input int en);
    vec_t v;
    v.rst   = 1'(r);
    v.sel_a = SEL_W'(sa);
    v.sel_b = SEL_W'(sb);
    v.sel_d = SEL_W'(sd);
    v.out_a = 1'(oa);
    v.out_b = 1'(ob);
    v.load  = 1'(ld);
    v.fload = 1'(fl);
    v.bus_d = WIDTH'(bd);
    v.exp_a = WIDTH'(ea);
    v.exp_b = WIDTH'(eb);
    v.exp_z = 1'(ez);
    v.exp_n = 1'(en);
    return v;
  endfunction

  // Inputs change on the falling edge; outputs are sampled 1ns later, well
  // before the next rising edge commits the vector.
  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    rst      = v.rst;
    regSelA  = v.sel_a;
    regSelB  = v.sel_b;
    regSelD  = v.sel_d;
    regOutA  = v.out_a;
    regOutB  = v.out_b;
    regLoad  = v.load;
    flagLoad = v.fload;
    busD     = v.bus_d;
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [WIDTH-1:0] actual,
                             input logic [WIDTH-1:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic checkAll(input string tag, input vec_t v);
    checkOutput({tag, " busA"}, busA, v.exp_a);
    checkOutput({tag, " busB"}, busB, v.exp_b);
    checkOutput({tag, " flagZ"}, WIDTH'(flagZ), WIDTH'(v.exp_z));
    checkOutput({tag, " flagN"}, WIDTH'(flagN), WIDTH'(v.exp_n));
  endtask

  logic [WIDTH-1:0] model_regs [REG_COUNT];
  logic             model_z, model_n;

  function automatic logic [WIDTH-1:0] model_read(input logic en, input logic [SEL_W-1:0] sel);
    if (!en || sel == 0) return '0;
    return model_regs[sel];
  endfunction

  initial begin
    vec_t v;
    $display("[TB] reg_file bench starting");

    // reset, then every read-port pairing must show zero
    applyStimulus(mk(1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
    for (int a = 0; a < REG_COUNT; a++) begin
      for (int b = 0; b < REG_COUNT; b++) begin
        applyStimulus(mk(0, a, b, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
        checkOutput($sformatf("reset rd a%0d", a), busA, '0);
        checkOutput($sformatf("reset rd b%0d", b), busB, '0);
      end
    end
    checkOutput("reset flagZ", WIDTH'(flagZ), '0);
    checkOutput("reset flagN", WIDTH'(flagN), '0);

    // expected values are the pre-edge view of each vector
    //          rst sa sb sd oa ob ld fl busD      expA     expB     z  n
    vecs.push_back(mk(0, 2, 3, 2, 1, 1, 1, 0, 2,       0,       0,       0, 0));
    vecs.push_back(mk(0, 2, 3, 3, 1, 1, 1, 0, 3,       2,       0,       0, 0));
    vecs.push_back(mk(0, 2, 3, 0, 1, 1, 0, 0, 0,       2,       3,       0, 0));
    vecs.push_back(mk(0, 2, 3, 0, 0, 1, 0, 0, 0,       0,       3,       0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 1, 1, 0, 'h1234,  0,       0,       0, 0));
    vecs.push_back(mk(0, 0, 2, 0, 1, 1, 0, 0, 0,       0,       2,       0, 0));
    vecs.push_back(mk(0, 1, 1, 1, 1, 1, 1, 0, 5,       0,       0,       0, 0));
    vecs.push_back(mk(0, 1, 1, 1, 1, 1, 1, 0, 9,       5,       5,       0, 0));
    vecs.push_back(mk(0, 1, 3, 0, 1, 1, 0, 0, 0,       9,       3,       0, 0));
    vecs.push_back(mk(0, 1, 2, 0, 1, 1, 0, 1, 'hFFF9,  9,       2,       0, 0));
    vecs.push_back(mk(0, 1, 2, 0, 1, 1, 0, 1, 0,       9,       2,       0, 1));
    vecs.push_back(mk(0, 1, 2, 0, 1, 1, 0, 0, 4,       9,       2,       1, 0));
    vecs.push_back(mk(0, 3, 1, 0, 1, 1, 0, 0, 0,       3,       9,       1, 0));
    vecs.push_back(mk(0, 5, 5, 5, 1, 1, 1, 1, 'h8000,  0,       0,       1, 0));
    vecs.push_back(mk(0, 5, 5, 0, 1, 1, 0, 0, 0,       'h8000,  'h8000,  0, 1));
    vecs.push_back(mk(0, 4, 2, 4, 1, 1, 1, 0, 3,       0,       2,       0, 1));
    vecs.push_back(mk(1, 4, 2, 4, 1, 1, 1, 1, 7,       3,       2,       0, 1));
    vecs.push_back(mk(0, 4, 2, 0, 1, 1, 0, 0, 0,       0,       0,       0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkAll($sformatf("vec%0d", i), vecs[i]);
    end

    // last table vector did not write, so the DUT now holds all zeros
    for (int i = 0; i < REG_COUNT; i++) model_regs[i] = '0;
    model_z = 1'b0;
    model_n = 1'b0;

    for (int n = 0; n < 400; n++) begin
      v.rst   = ($urandom_range(0, 31) == 0);
      v.sel_a = SEL_W'($urandom_range(0, REG_COUNT - 1));
      v.sel_b = SEL_W'($urandom_range(0, REG_COUNT - 1));
      v.sel_d = SEL_W'($urandom_range(0, REG_COUNT - 1));
      v.out_a = ($urandom_range(0, 3) != 0);
      v.out_b = ($urandom_range(0, 3) != 0);
      v.load  = ($urandom_range(0, 1) == 1);
      v.fload = ($urandom_range(0, 2) == 0);
      v.bus_d = ($urandom_range(0, 7) == 0) ? '0 : WIDTH'($urandom);
      v.exp_a = model_read(v.out_a, v.sel_a);
      v.exp_b = model_read(v.out_b, v.sel_b);
      v.exp_z = model_z;
      v.exp_n = model_n;
      applyStimulus(v);
      checkAll($sformatf("rand%0d", n), v);
      if (v.rst) begin
        for (int i = 0; i < REG_COUNT; i++) model_regs[i] = '0;
        model_z = 1'b0;
        model_n = 1'b0;
      end else begin
        if (v.load && v.sel_d != 0) model_regs[v.sel_d] = v.bus_d;
        if (v.fload) begin
          model_z = (v.bus_d == 0);
          model_n = ($signed(v.bus_d) < 0);
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
